// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the mips_cpu_bus multicycle CPU.
// Holds the reset vector, opcode/funct encodings, the bus FSM state type and
// the ALU operation type. No ports.
package mips_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

  // Primary opcodes (ir[31:26])
  localparam logic [5:0] OpSpecial = 6'h00;
  localparam logic [5:0] OpJ       = 6'h02;
  localparam logic [5:0] OpJal     = 6'h03;
  localparam logic [5:0] OpBeq     = 6'h04;
  localparam logic [5:0] OpBne     = 6'h05;
  localparam logic [5:0] OpAddiu   = 6'h09;
  localparam logic [5:0] OpSlti    = 6'h0A;
  localparam logic [5:0] OpSltiu   = 6'h0B;
  localparam logic [5:0] OpAndi    = 6'h0C;
  localparam logic [5:0] OpOri     = 6'h0D;
  localparam logic [5:0] OpXori    = 6'h0E;
  localparam logic [5:0] OpLui     = 6'h0F;
  localparam logic [5:0] OpLb      = 6'h20;
  localparam logic [5:0] OpLh      = 6'h21;
  localparam logic [5:0] OpLw      = 6'h23;
  localparam logic [5:0] OpLbu     = 6'h24;
  localparam logic [5:0] OpLhu     = 6'h25;
  localparam logic [5:0] OpSb      = 6'h28;
  localparam logic [5:0] OpSh      = 6'h29;
  localparam logic [5:0] OpSw      = 6'h2B;

  // SPECIAL funct codes (ir[5:0])
  localparam logic [5:0] FnSll   = 6'h00;
  localparam logic [5:0] FnSrl   = 6'h02;
  localparam logic [5:0] FnSra   = 6'h03;
  localparam logic [5:0] FnSllv  = 6'h04;
  localparam logic [5:0] FnSrlv  = 6'h06;
  localparam logic [5:0] FnSrav  = 6'h07;
  localparam logic [5:0] FnJr    = 6'h08;
  localparam logic [5:0] FnMfhi  = 6'h10;
  localparam logic [5:0] FnMthi  = 6'h11;
  localparam logic [5:0] FnMflo  = 6'h12;
  localparam logic [5:0] FnMtlo  = 6'h13;
  localparam logic [5:0] FnMult  = 6'h18;
  localparam logic [5:0] FnMultu = 6'h19;
  localparam logic [5:0] FnAddu  = 6'h21;
  localparam logic [5:0] FnSubu  = 6'h23;
  localparam logic [5:0] FnAnd   = 6'h24;
  localparam logic [5:0] FnOr    = 6'h25;
  localparam logic [5:0] FnXor   = 6'h26;
  localparam logic [5:0] FnSlt   = 6'h2A;
  localparam logic [5:0] FnSltu  = 6'h2B;

  typedef enum logic [1:0] {StFetch, StExec, StMem, StHalt} state_t;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluXor, AluSlt, AluSltu,
    AluSll, AluSrl, AluSra, AluLui, AluHi, AluLo, AluLink
  } alu_op_t;

endpackage

// File: rtl/mips_regfile.sv
// mips_regfile: 32x32 general-purpose register file.
// Ports: clk, reset (async, active-low, clears all registers);
//   raddr_a/rdata_a, raddr_b/rdata_b: asynchronous read ports;
//   we/waddr/wdata: synchronous write port (writes to $0 are dropped);
//   reg_v0: live value of $2.
module mips_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  raddr_a,
  output logic [31:0] rdata_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_b,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  output logic [31:0] reg_v0
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? 32'h0 : regs_q[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? 32'h0 : regs_q[raddr_b];
  assign reg_v0  = regs_q[2];

endmodule

// File: rtl/mips_cpu_bus.sv
// mips_cpu_bus: multicycle MIPS-I subset CPU with one Avalon-MM master port
// shared by instruction fetch and data access. Halts when a jump lands on 0.
// Ports: clk, reset (async, active-low); active (low once halted);
//   register_v0 ($2); Avalon master: address, read, write, waitrequest,
//   writedata, byteenable, readdata.
module mips_cpu_bus #(
  parameter logic [31:0] RESET_VECTOR = mips_pkg::RESET_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);
  import mips_pkg::*;

  state_t      state_q, state_d;
  logic [31:0] pc_q, npc_q, ir_q, hi_q, lo_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_be_q;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] imm_sext, imm_zext, rs_val, rt_val;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign imm_zext = {16'h0, ir_q[15:0]};

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  mips_regfile u_regfile (
    .clk     (clk),
    .reset   (reset),
    .raddr_a (rs),
    .rdata_a (rs_val),
    .raddr_b (rt),
    .rdata_b (rt_val),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .reg_v0  (register_v0)
  );

  // Decode
  alu_op_t     alu_op;
  logic [31:0] alu_b, alu_res, branch_target;
  logic [4:0]  alu_sa, alu_dst;
  logic        alu_wb, is_load, is_store, mul_en, mul_signed, hi_we, lo_we, branch;

  always_comb begin
    alu_op        = AluAdd;
    alu_b         = rt_val;
    alu_sa        = shamt;
    alu_dst       = rd;
    alu_wb        = 1'b0;
    is_load       = 1'b0;
    is_store      = 1'b0;
    mul_en        = 1'b0;
    mul_signed    = 1'b0;
    hi_we         = 1'b0;
    lo_we         = 1'b0;
    branch        = 1'b0;
    branch_target = npc_q + {imm_sext[29:0], 2'b00};
    case (opcode)
      OpSpecial: begin
        alu_wb = 1'b1;
        case (funct)
          FnSll:   alu_op = AluSll;
          FnSrl:   alu_op = AluSrl;
          FnSra:   alu_op = AluSra;
          FnSllv:  begin alu_op = AluSll; alu_sa = rs_val[4:0]; end
          FnSrlv:  begin alu_op = AluSrl; alu_sa = rs_val[4:0]; end
          FnSrav:  begin alu_op = AluSra; alu_sa = rs_val[4:0]; end
          FnJr:    begin alu_wb = 1'b0; branch = 1'b1; branch_target = rs_val; end
          FnMfhi:  alu_op = AluHi;
          FnMflo:  alu_op = AluLo;
          FnMthi:  begin alu_wb = 1'b0; hi_we = 1'b1; end
          FnMtlo:  begin alu_wb = 1'b0; lo_we = 1'b1; end
          FnMult:  begin alu_wb = 1'b0; mul_en = 1'b1; mul_signed = 1'b1; end
          FnMultu: begin alu_wb = 1'b0; mul_en = 1'b1; end
          FnAddu:  alu_op = AluAdd;
          FnSubu:  alu_op = AluSub;
          FnAnd:   alu_op = AluAnd;
          FnOr:    alu_op = AluOr;
          FnXor:   alu_op = AluXor;
          FnSlt:   alu_op = AluSlt;
          FnSltu:  alu_op = AluSltu;
          default: alu_wb = 1'b0;
        endcase
      end
      OpJ: begin
        branch        = 1'b1;
        branch_target = {npc_q[31:28], ir_q[25:0], 2'b00};
      end
      OpJal: begin
        branch        = 1'b1;
        branch_target = {npc_q[31:28], ir_q[25:0], 2'b00};
        alu_wb        = 1'b1;
        alu_dst       = 5'd31;
        alu_op        = AluLink;
      end
      OpBeq:   branch = (rs_val == rt_val);
      OpBne:   branch = (rs_val != rt_val);
      OpAddiu: begin alu_wb = 1'b1; alu_dst = rt; alu_b = imm_sext; end
      OpSlti:  begin alu_wb = 1'b1; alu_dst = rt; alu_b = imm_sext; alu_op = AluSlt; end
      OpSltiu: begin alu_wb = 1'b1; alu_dst = rt; alu_b = imm_sext; alu_op = AluSltu; end
      OpAndi:  begin alu_wb = 1'b1; alu_dst = rt; alu_b = imm_zext; alu_op = AluAnd; end
      OpOri:   begin alu_wb = 1'b1; alu_dst = rt; alu_b = imm_zext; alu_op = AluOr; end
      OpXori:  begin alu_wb = 1'b1; alu_dst = rt; alu_b = imm_zext; alu_op = AluXor; end
      OpLui:   begin alu_wb = 1'b1; alu_dst = rt; alu_b = imm_zext; alu_op = AluLui; end
      OpLb, OpLh, OpLw, OpLbu, OpLhu: is_load = 1'b1;
      OpSb, OpSh, OpSw:               is_store = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    case (alu_op)
      AluAdd:  alu_res = rs_val + alu_b;
      AluSub:  alu_res = rs_val - alu_b;
      AluAnd:  alu_res = rs_val & alu_b;
      AluOr:   alu_res = rs_val | alu_b;
      AluXor:  alu_res = rs_val ^ alu_b;
      AluSlt:  alu_res = {31'h0, $signed(rs_val) < $signed(alu_b)};
      AluSltu: alu_res = {31'h0, rs_val < alu_b};
      AluSll:  alu_res = alu_b << alu_sa;
      AluSrl:  alu_res = alu_b >> alu_sa;
      AluSra:  alu_res = $unsigned($signed(alu_b) >>> alu_sa);
      AluLui:  alu_res = {alu_b[15:0], 16'h0};
      AluHi:   alu_res = hi_q;
      AluLo:   alu_res = lo_q;
      AluLink: alu_res = npc_q + 32'd4;
      default: alu_res = 32'h0;
    endcase
  end

  // Extending both operands to 64 bits makes one unsigned multiply serve MULT and MULTU.
  logic [63:0] mul_a, mul_b, prod;
  assign mul_a = {{32{mul_signed & rs_val[31]}}, rs_val};
  assign mul_b = {{32{mul_signed & rt_val[31]}}, rt_val};
  assign prod  = mul_a * mul_b;

  // Data-access lanes
  logic [31:0] ea, st_data;
  logic [3:0]  st_be;
  assign ea = rs_val + imm_sext;

  always_comb begin
    st_be   = 4'b1111;
    st_data = rt_val;
    case (opcode)
      OpLb, OpLbu, OpSb: begin st_be = 4'b0001 << ea[1:0]; st_data = {4{rt_val[7:0]}}; end
      OpLh, OpLhu, OpSh: begin st_be = ea[1] ? 4'b1100 : 4'b0011; st_data = {2{rt_val[15:0]}}; end
      default: ;
    endcase
  end

  logic [31:0] rd_byte, rd_half, load_val;
  assign rd_byte = readdata >> {mem_addr_q[1:0], 3'b000};
  assign rd_half = readdata >> {mem_addr_q[1], 4'b0000};

  always_comb begin
    case (opcode)
      OpLb:    load_val = {{24{rd_byte[7]}}, rd_byte[7:0]};
      OpLbu:   load_val = {24'h0, rd_byte[7:0]};
      OpLh:    load_val = {{16{rd_half[15]}}, rd_half[15:0]};
      OpLhu:   load_val = {16'h0, rd_half[15:0]};
      default: load_val = readdata;
    endcase
  end

  logic retire, mem_done;
  assign mem_done = (state_q == StMem) && !waitrequest;
  assign retire   = ((state_q == StExec) && !(is_load || is_store)) || mem_done;

  always_comb begin
    rf_we    = (state_q == StExec) && alu_wb;
    rf_waddr = alu_dst;
    rf_wdata = alu_res;
    if (mem_done && is_load) begin
      rf_we    = 1'b1;
      rf_waddr = rt;
      rf_wdata = load_val;
    end
  end

  // The next fetch address is npc_q; a zero there ends execution.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: if (!waitrequest) state_d = StExec;
      StExec:  begin
        if (is_load || is_store) state_d = StMem;
        else                     state_d = (npc_q == 32'h0) ? StHalt : StFetch;
      end
      StMem:   if (!waitrequest) state_d = (npc_q == 32'h0) ? StHalt : StFetch;
      default: state_d = StHalt;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StFetch;
      pc_q        <= RESET_VECTOR;
      npc_q       <= RESET_VECTOR + 32'd4;
      ir_q        <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == StFetch) && !waitrequest) ir_q <= readdata;
      if (state_q == StExec) begin
        mem_addr_q  <= ea;
        mem_wdata_q <= st_data;
        mem_be_q    <= st_be;
        if (hi_we)  hi_q <= rs_val;
        if (lo_we)  lo_q <= rs_val;
        if (mul_en) {hi_q, lo_q} <= prod;
      end
      if (retire) begin
        pc_q  <= npc_q;
        npc_q <= branch ? branch_target : npc_q + 32'd4;
      end
    end
  end

  // Gating with reset drops any request the moment reset is asserted.
  always_comb begin
    read       = 1'b0;
    write      = 1'b0;
    address    = 32'h0;
    byteenable = 4'h0;
    writedata  = 32'h0;
    if (reset) begin
      case (state_q)
        StFetch: begin
          read       = 1'b1;
          address    = pc_q;
          byteenable = 4'b1111;
        end
        StMem: begin
          address    = {mem_addr_q[31:2], 2'b00};
          byteenable = mem_be_q;
          if (is_store) begin
            write     = 1'b1;
            writedata = mem_wdata_q;
          end else begin
            read = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign active = (state_q != StHalt);

endmodule

// File: tb/tb_mips_cpu_bus.sv
// tb_mips_cpu_bus: directed bench for mips_cpu_bus. A small Avalon memory
// model serves code at 0xBFC00000 and data at 0..1023; data memory reloads
// its preset contents whenever reset is asserted.
module tb_mips_cpu_bus;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        active, write, read, waitrequest;
  logic [31:0] register_v0, address, writedata, readdata;
  logic [3:0]  byteenable;

  mips_cpu_bus dut (
    .clk         (clk),
    .reset       (reset),
    .active      (active),
    .register_v0 (register_v0),
    .address     (address),
    .write       (write),
    .read        (read),
    .waitrequest (waitrequest),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .readdata    (readdata)
  );

  always #5 clk = ~clk;

  // Memory model
  logic [31:0] code_mem [64];
  logic [31:0] dmem [256];
  logic        stall_en = 1'b0;
  int unsigned wait_cnt = 0;

  always_comb begin
    readdata = 32'h0;
    if (address[31:20] == 12'hBFC) readdata = code_mem[address[7:2]];
    else if (address < 32'd1024)   readdata = dmem[address[9:2]];
  end

  // Optionally stall each write for three cycles.
  assign waitrequest = stall_en && write && (wait_cnt < 3);

  always @(posedge clk) begin
    if (write && waitrequest) wait_cnt <= wait_cnt + 1;
    else if (!write)          wait_cnt <= 0;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 32'h0;
      dmem[25]  <= 32'd123;
      dmem[102] <= 32'hAABBCCDD;
    end else if (write && !waitrequest && address < 32'd1024) begin
      for (int b = 0; b < 4; b++)
        if (byteenable[b]) dmem[address[9:2]][8*b +: 8] <= writedata[8*b +: 8];
    end
  end

  // Bus monitor
  int          write_cycles = 0, w_unstable = 0, rw_both = 0, post_halt_bus = 0;
  logic [31:0] w_addr0 = 0, w_data0 = 0, last_fetch = 0, last_daddr = 0;
  logic [3:0]  w_be0 = 0, last_dbe = 0;

  always @(negedge clk) begin
    if (reset) begin
      if (read && write) rw_both <= rw_both + 1;
      if (write) begin
        if (write_cycles == 0) begin
          w_addr0 <= address; w_data0 <= writedata; w_be0 <= byteenable;
        end else if (address != w_addr0 || writedata != w_data0 || byteenable != w_be0) begin
          w_unstable <= w_unstable + 1;
        end
        write_cycles <= write_cycles + 1;
      end
      if (read && address[31:20] == 12'hBFC) last_fetch <= address;
      if (read && address < 32'd1024) begin last_daddr <= address; last_dbe <= byteenable; end
      if (!active && (read || write)) post_halt_bus <= post_halt_bus + 1;
    end
  end

  // Checking
  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  localparam logic [31:0] Nop = 32'h0;

  task automatic clear_code();
    for (int i = 0; i < 64; i++) code_mem[i] = Nop;
  endtask

  // Reset, release, and run until halt (bounded).
  task automatic run_prog(input string name);
    int cyc;
    @(negedge clk) reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    while (active && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, " halts"}, {31'h0, active}, 32'h0);
  endtask

  typedef struct {
    string       name;
    logic [31:0] i0, i1, i2;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] c, input logic [4:0] r, input logic [31:0] e);
    vec_t v;
    v.name = nm; v.i0 = a; v.i1 = b; v.i2 = c; v.rd = r; v.exp = e;
    vecs.push_back(v);
  endtask

  logic [31:0] subu_neg;  // $3 = 123 - 404 = 0xFFFFFEE7
  int          snap;
  logic [31:0] v0_snap;

  initial begin
    subu_neg = enc_r(5'd2, 5'd1, 5'd3, 5'd0, 6'h23);
    // Each vector runs: $1=404, $2=123, i0..i2, ADDU $2,rd,$0, JR $0, NOP
    add("or",      enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h25), Nop, Nop, 5'd3, 32'd511);
    add("slt_a",   enc_r(5'd1, 5'd2, 5'd6, 5'd0, 6'h2A), Nop, Nop, 5'd6, 32'd0);
    add("slt_b",   enc_r(5'd2, 5'd1, 5'd7, 5'd0, 6'h2A), Nop, Nop, 5'd7, 32'd1);
    add("subu",    enc_r(5'd1, 5'd2, 5'd14, 5'd0, 6'h23), Nop, Nop, 5'd14, 32'd281);
    add("sll",     enc_r(5'd0, 5'd1, 5'd5, 5'd2, 6'h00), Nop, Nop, 5'd5, 32'd1616);
    add("and",     enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h24), Nop, Nop, 5'd3, 32'd16);
    add("xor",     enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h26), Nop, Nop, 5'd3, 32'd495);
    add("addu",    enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), Nop, Nop, 5'd3, 32'd527);
    add("sltu",    enc_r(5'd2, 5'd1, 5'd3, 5'd0, 6'h2B), Nop, Nop, 5'd3, 32'd1);
    add("andi",    enc_i(6'h0C, 5'd1, 5'd3, 16'hFFFF), Nop, Nop, 5'd3, 32'd404);
    add("xori",    enc_i(6'h0E, 5'd1, 5'd3, 16'h8000), Nop, Nop, 5'd3, 32'h00008194);
    add("addiu",   enc_i(6'h09, 5'd1, 5'd3, 16'hFFFC), Nop, Nop, 5'd3, 32'd400);
    add("sltiu",   enc_i(6'h0B, 5'd1, 5'd3, 16'hFFFF), Nop, Nop, 5'd3, 32'd1);
    add("slti",    enc_i(6'h0A, 5'd1, 5'd3, 16'hFFFF), Nop, Nop, 5'd3, 32'd0);
    add("lui",     enc_i(6'h0F, 5'd0, 5'd3, 16'h1234), Nop, Nop, 5'd3, 32'h12340000);
    add("sra",     subu_neg, enc_r(5'd0, 5'd3, 5'd3, 5'd4, 6'h03), Nop, 5'd3, 32'hFFFFFFEE);
    add("srl",     subu_neg, enc_r(5'd0, 5'd3, 5'd3, 5'd28, 6'h02), Nop, 5'd3, 32'h0000000F);
    add("sllv",    enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h04), Nop, Nop, 5'd3, 32'h07B00000);
    add("srav",    subu_neg, enc_r(5'd1, 5'd3, 5'd3, 5'd0, 6'h07), Nop, 5'd3, 32'hFFFFFFFF);
    add("srlv",    subu_neg, enc_r(5'd1, 5'd3, 5'd3, 5'd0, 6'h06), Nop, 5'd3, 32'h00000FFF);
    add("mult_lo", enc_r(5'd1, 5'd2, 5'd0, 5'd0, 6'h18), enc_r(5'd0, 5'd0, 5'd3, 5'd0, 6'h12),
        Nop, 5'd3, 32'd49692);
    add("mult_hi", subu_neg, enc_r(5'd3, 5'd1, 5'd0, 5'd0, 6'h18),
        enc_r(5'd0, 5'd0, 5'd3, 5'd0, 6'h10), 5'd3, 32'hFFFFFFFF);
    add("multu_hi", subu_neg, enc_r(5'd3, 5'd1, 5'd0, 5'd0, 6'h19),
        enc_r(5'd0, 5'd0, 5'd3, 5'd0, 6'h10), 5'd3, 32'd403);
    add("mtlo",    enc_r(5'd1, 5'd0, 5'd0, 5'd0, 6'h13), enc_r(5'd0, 5'd0, 5'd3, 5'd0, 6'h12),
        Nop, 5'd3, 32'd404);
    add("beq_taken", enc_i(6'h04, 5'd0, 5'd0, 16'd2), enc_i(6'h09, 5'd0, 5'd3, 16'd5),
        enc_i(6'h09, 5'd0, 5'd3, 16'd7), 5'd3, 32'd5);
    add("bne_not",  enc_i(6'h05, 5'd1, 5'd1, 16'd2), enc_i(6'h09, 5'd0, 5'd3, 16'd5),
        enc_i(6'h09, 5'd0, 5'd3, 16'd7), 5'd3, 32'd7);
    add("jal_link", {6'h03, 26'h3F00005}, Nop, enc_i(6'h09, 5'd0, 5'd31, 16'd0),
        5'd31, 32'hBFC00010);
    add("wr_zero", enc_i(6'h09, 5'd0, 5'd0, 16'd5), Nop, Nop, 5'd0, 32'd0);
    add("unsupported", enc_i(6'h3F, 5'd0, 5'd3, 16'd77), Nop, Nop, 5'd3, 32'd0);
    add("lhu",     enc_i(6'h25, 5'd1, 5'd3, 16'd6), Nop, Nop, 5'd3, 32'h0000AABB);
    add("lh",      enc_i(6'h21, 5'd1, 5'd3, 16'd6), Nop, Nop, 5'd3, 32'hFFFFAABB);
    add("sb_lw",   enc_i(6'h28, 5'd0, 5'd2, 16'd201), enc_i(6'h23, 5'd0, 5'd3, 16'd200),
        Nop, 5'd3, 32'h00007B00);
    add("sh_lw",   enc_i(6'h29, 5'd0, 5'd1, 16'd102), enc_i(6'h23, 5'd0, 5'd3, 16'd100),
        Nop, 5'd3, 32'h0194007B);

    // Reset state and first bus cycle
    clear_code();
    #3 reset = 1'b0;
    @(negedge clk);
    check("rst read", {31'h0, read}, 32'h0);
    check("rst write", {31'h0, write}, 32'h0);
    check("rst address", address, 32'h0);
    check("rst byteenable", {28'h0, byteenable}, 32'h0);
    check("rst writedata", writedata, 32'h0);
    check("rst active", {31'h0, active}, 32'h1);
    check("rst v0", register_v0, 32'h0);
    reset = 1'b1;
    #1;
    check("first read", {31'h0, read}, 32'h1);
    check("first address", address, 32'hBFC00000);
    check("first byteenable", {28'h0, byteenable}, 32'hF);
    check("first active", {31'h0, active}, 32'h1);
    reset = 1'b0;
    #1;
    check("async drop read", {31'h0, read}, 32'h0);
    reset = 1'b1;

    // SW with three wait cycles: outputs must hold
    clear_code();
    code_mem[0] = enc_i(6'h09, 5'd0, 5'd1, 16'd404);
    code_mem[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'd200);
    code_mem[2] = enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
    stall_en = 1'b1;
    run_prog("sw_stall");
    stall_en = 1'b0;
    check("sw write cycles", write_cycles, 32'd4);
    check("sw address", w_addr0, 32'd200);
    check("sw writedata", w_data0, 32'd404);
    check("sw byteenable", {28'h0, w_be0}, 32'hF);
    check("sw held stable", w_unstable, 32'd0);
    check("sw stored", dmem[50], 32'd404);

    // LW, MTHI, MFHI into $v0
    clear_code();
    code_mem[0] = enc_i(6'h23, 5'd0, 5'd1, 16'd100);
    code_mem[1] = enc_r(5'd1, 5'd0, 5'd0, 5'd0, 6'h11);
    code_mem[2] = enc_r(5'd0, 5'd0, 5'd2, 5'd0, 6'h10);
    code_mem[3] = enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
    run_prog("lw_hi");
    check("lw_hi v0", register_v0, 32'd123);
    check("lw address", last_daddr, 32'd100);
    check("lw byteenable", {28'h0, last_dbe}, 32'hF);

    // LB / LBU from word 408
    for (int k = 0; k < 2; k++) begin
      clear_code();
      code_mem[0] = enc_i(6'h09, 5'd0, 5'd1, 16'd404);
      code_mem[1] = enc_i((k == 0) ? 6'h20 : 6'h24, 5'd1, 5'd15, 16'd4);
      code_mem[2] = enc_r(5'd15, 5'd0, 5'd2, 5'd0, 6'h21);
      code_mem[3] = enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
      run_prog((k == 0) ? "lb" : "lbu");
      check((k == 0) ? "lb v0" : "lbu v0", register_v0, (k == 0) ? 32'hFFFFFFDD : 32'h000000DD);
      check("lb address", last_daddr, 32'd408);
      check("lb byteenable", {28'h0, last_dbe}, 32'h1);
    end

    // Halt: delay slot fetched, then bus idle and $v0 retained
    clear_code();
    code_mem[0] = enc_i(6'h09, 5'd0, 5'd2, 16'd77);
    code_mem[1] = enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
    code_mem[2] = Nop;
    code_mem[3] = enc_i(6'h09, 5'd0, 5'd2, 16'd99);
    run_prog("halt");
    snap = post_halt_bus;
    v0_snap = register_v0;
    repeat (20) @(posedge clk);
    #1;
    check("halt delay slot fetched", last_fetch, 32'hBFC00008);
    check("halt active", {31'h0, active}, 32'h0);
    check("halt bus idle", post_halt_bus - snap, 32'd0);
    check("halt v0", register_v0, 32'd77);
    check("halt v0 held", register_v0, v0_snap);

    // Table-driven ALU/branch/memory vectors
    foreach (vecs[k]) begin
      clear_code();
      code_mem[0] = enc_i(6'h09, 5'd0, 5'd1, 16'd404);
      code_mem[1] = enc_i(6'h09, 5'd0, 5'd2, 16'd123);
      code_mem[2] = vecs[k].i0;
      code_mem[3] = vecs[k].i1;
      code_mem[4] = vecs[k].i2;
      code_mem[5] = enc_r(vecs[k].rd, 5'd0, 5'd2, 5'd0, 6'h21);
      code_mem[6] = enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
      run_prog(vecs[k].name);
      check(vecs[k].name, register_v0, vecs[k].exp);
    end

    check("read and write never together", rw_both, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
